// File: rtl/demux_1xn_stream_pkg.sv
// Shared types and helpers for the 1-to-N stream demultiplexer.
// Holds the routing FSM state encoding, the optional counter width and the
// select range check used on the first beat of every packet.
package demux_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUTE = 2'd1,
    DROP  = 2'd2
  } state_t;

  localparam int CNT_W = 16;

  // True when the select addresses a lane that physically exists.
  function automatic logic sel_valid(input int unsigned sel, input int unsigned n);
    return (sel < n);
  endfunction

endpackage

// File: rtl/demux_1xn_stream_out_reg.sv
// Single-entry output register shared by all lanes of the demultiplexer.
// Stores one beat together with its destination lane, decodes the per-lane
// valid and reports whether it can take a new beat this cycle (empty, or the
// held beat is leaving on its own lane).
module demux_out_reg #(
  parameter int N_CH   = 4,
  parameter int DATA_W = 8,
  parameter int SEL_W  = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_load,
  input  logic [DATA_W-1:0]        i_load_data,
  input  logic                     i_load_last,
  input  logic [SEL_W-1:0]         i_load_ch,
  input  logic [N_CH-1:0]          i_out_ready,
  output logic [N_CH-1:0]          o_out_valid,
  output logic [N_CH*DATA_W-1:0]   o_out_data,
  output logic [N_CH-1:0]          o_out_last,
  output logic                     o_can_accept
);

  logic              r_valid;
  logic [SEL_W-1:0]  r_ch;
  logic [DATA_W-1:0] r_data;
  logic              r_last;

  logic [N_CH-1:0]   w_lane_hit;
  logic              w_fire;

  // Per-lane decode of the held beat; only the owning lane sees it.
  always_comb begin
    w_lane_hit = '0;
    for (int k = 0; k < N_CH; k++) begin
      w_lane_hit[k] = r_valid && (r_ch == SEL_W'(k));
    end
  end

  // Only the ready of the lane that owns the beat can release it.
  assign w_fire       = |(w_lane_hit & i_out_ready);
  assign o_can_accept = !r_valid || w_fire;

  // Load wins over drain so a new beat can replace a departing one in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_ch    <= '0;
      r_data  <= '0;
      r_last  <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_ch    <= i_load_ch;
      r_data  <= i_load_data;
      r_last  <= i_load_last;
    end else if (w_fire) begin
      r_valid <= 1'b0;
    end
  end

  // Fan the held beat out to its lane and keep every other lane at zero.
  always_comb begin
    o_out_valid = '0;
    o_out_data  = '0;
    o_out_last  = '0;
    for (int k = 0; k < N_CH; k++) begin
      o_out_valid[k] = w_lane_hit[k];
      if (w_lane_hit[k]) begin
        o_out_data[k*DATA_W +: DATA_W] = r_data;
        o_out_last[k]                  = r_last;
      end
    end
  end

endmodule

// File: rtl/demux_1xn_stream.sv
// Registered 1-to-N stream demultiplexer with packet-atomic routing.
// The lane is chosen from in_sel on the first beat of a packet and held until
// the last beat; packets aimed at a non-existent lane are swallowed and flagged
// on err. Define DEMUX_1XN_CNT_EN to add per-lane packet counters (pkt_cnt) and
// a dropped-packet counter (drop_cnt).
module demux_1xn_stream
  import demux_pkg::*;
#(
  parameter int N_CH   = 4,
  parameter int DATA_W = 8,
  parameter int SEL_W  = (N_CH > 2) ? $clog2(N_CH) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_W-1:0]       in_data,
  input  logic [SEL_W-1:0]        in_sel,
  input  logic                    in_last,
  output logic [N_CH-1:0]         out_valid,
  input  logic [N_CH-1:0]         out_ready,
  output logic [N_CH*DATA_W-1:0]  out_data,
  output logic [N_CH-1:0]         out_last,
  output logic                    busy,
  output logic                    err
`ifdef DEMUX_1XN_CNT_EN
  ,
  output logic [N_CH*CNT_W-1:0]   pkt_cnt,
  output logic [CNT_W-1:0]        drop_cnt
`endif
);

  state_t           r_state;
  state_t           w_next;
  logic [SEL_W-1:0] r_cur_ch;
  logic             r_err;

  logic             w_sel_ok;
  logic             w_can_accept;
  logic             w_accept;
  logic             w_load;
  logic [SEL_W-1:0] w_load_ch;
  logic             w_latch_ch;
  logic             w_err_next;

  assign w_sel_ok = sel_valid(32'(in_sel), N_CH);

  // Ready follows the output register except when the beat is going to be dropped.
  always_comb begin
    in_ready = w_can_accept;
    case (r_state)
      IDLE:    if (!w_sel_ok) in_ready = 1'b1;
      ROUTE:   in_ready = w_can_accept;
      DROP:    in_ready = 1'b1;
      default: in_ready = w_can_accept;
    endcase
  end

  assign w_accept = in_valid && in_ready;

  // Next-state, register load and error decisions for each accepted beat.
  always_comb begin
    w_next     = r_state;
    w_load     = 1'b0;
    w_load_ch  = r_cur_ch;
    w_latch_ch = 1'b0;
    w_err_next = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (w_sel_ok) begin
            w_load     = 1'b1;
            w_load_ch  = in_sel;
            w_latch_ch = 1'b1;
            if (!in_last) w_next = ROUTE;
          end else begin
            w_err_next = 1'b1;
            if (!in_last) w_next = DROP;
          end
        end
      end
      ROUTE: begin
        if (w_accept) begin
          w_load = 1'b1;
          if (in_last) w_next = IDLE;
        end
      end
      DROP: begin
        if (w_accept && in_last) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // State, locked channel and registered error pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_cur_ch <= '0;
      r_err    <= 1'b0;
    end else begin
      r_state <= w_next;
      r_err   <= w_err_next;
      if (w_latch_ch) r_cur_ch <= in_sel;
    end
  end

  assign busy = (r_state != IDLE);
  assign err  = r_err;

  demux_out_reg #(
    .N_CH   (N_CH),
    .DATA_W (DATA_W),
    .SEL_W  (SEL_W)
  ) u_out_reg (
    .clk          (clk),
    .rst          (rst),
    .i_load       (w_load),
    .i_load_data  (in_data),
    .i_load_last  (in_last),
    .i_load_ch    (w_load_ch),
    .i_out_ready  (out_ready),
    .o_out_valid  (out_valid),
    .o_out_data   (out_data),
    .o_out_last   (out_last),
    .o_can_accept (w_can_accept)
  );

`ifdef DEMUX_1XN_CNT_EN
  logic [N_CH*CNT_W-1:0] r_pkt_cnt;
  logic [CNT_W-1:0]      r_drop_cnt;

  // Count completed packets per lane and dropped packets; both wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pkt_cnt  <= '0;
      r_drop_cnt <= '0;
    end else begin
      for (int k = 0; k < N_CH; k++) begin
        if (out_valid[k] && out_ready[k] && out_last[k]) begin
          r_pkt_cnt[k*CNT_W +: CNT_W] <= r_pkt_cnt[k*CNT_W +: CNT_W] + CNT_W'(1);
        end
      end
      if (r_err) r_drop_cnt <= r_drop_cnt + CNT_W'(1);
    end
  end

  assign pkt_cnt  = r_pkt_cnt;
  assign drop_cnt = r_drop_cnt;
`endif

endmodule

// File: tb/tb_demux_1xn_stream.sv
// Self-checking bench for demux_1xn_stream: a 4-lane instance driven through a
// scoreboard of expected beats, plus a 3-lane instance for out-of-range drops.
module tb_demux_1xn_stream;

  typedef struct packed {
    logic [1:0] ch;
    logic       last;
    logic [7:0] data;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst;

  logic        inValid;
  logic        inReady;
  logic [7:0]  inData;
  logic [1:0]  inSel;
  logic        inLast;
  logic [3:0]  outValid;
  logic [3:0]  outReady;
  logic [31:0] outData;
  logic [3:0]  outLast;
  logic        busy;
  logic        err;

  logic        d3InValid;
  logic        d3InReady;
  logic [7:0]  d3InData;
  logic [1:0]  d3InSel;
  logic        d3InLast;
  logic [2:0]  d3OutValid;
  logic [2:0]  d3OutReady;
  logic [23:0] d3OutData;
  logic [2:0]  d3OutLast;
  logic        d3Busy;
  logic        d3Err;

`ifdef DEMUX_1XN_CNT_EN
  logic [63:0] pktCnt;
  logic [15:0] dropCnt;
  logic [47:0] d3PktCnt;
  logic [15:0] d3DropCnt;
`endif

  int    checks = 0;
  int    errors = 0;
  beat_t expQ[$];
  logic  mInPkt = 1'b0;
  logic [1:0] mLane = 2'd0;
  int    d3ErrPulses = 0;
  int    d3BusyCycles = 0;

  always #5 clk = ~clk;

  demux_1xn_stream #(.N_CH(4), .DATA_W(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(inValid), .in_ready(inReady), .in_data(inData),
    .in_sel(inSel), .in_last(inLast),
    .out_valid(outValid), .out_ready(outReady), .out_data(outData),
    .out_last(outLast), .busy(busy), .err(err)
`ifdef DEMUX_1XN_CNT_EN
    , .pkt_cnt(pktCnt), .drop_cnt(dropCnt)
`endif
  );

  demux_1xn_stream #(.N_CH(3), .DATA_W(8)) dut3 (
    .clk(clk), .rst(rst),
    .in_valid(d3InValid), .in_ready(d3InReady), .in_data(d3InData),
    .in_sel(d3InSel), .in_last(d3InLast),
    .out_valid(d3OutValid), .out_ready(d3OutReady), .out_data(d3OutData),
    .out_last(d3OutLast), .busy(d3Busy), .err(d3Err)
`ifdef DEMUX_1XN_CNT_EN
    , .pkt_cnt(d3PktCnt), .drop_cnt(d3DropCnt)
`endif
  );

  // Watchdog so a stuck handshake can never hang the run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Scoreboard monitor: pops an expected beat whenever a lane handshakes.
  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      assert ($countones(outValid) <= 1) else begin
        errors++;
        $error("[TB] FAIL onehot observed=%b expected=at most one bit", outValid);
      end
      for (int k = 0; k < 4; k++) begin
        checks++;
        assert (outValid[k] || (outData[k*8 +: 8] === 8'h00 && outLast[k] === 1'b0)) else begin
          errors++;
          $error("[TB] FAIL idle_lane%0d observed=%h/%b expected=00/0", k, outData[k*8 +: 8], outLast[k]);
        end
        if (outValid[k] && outReady[k]) begin
          beat_t obs;
          beat_t exp;
          obs.ch   = 2'(k);
          obs.last = outLast[k];
          obs.data = outData[k*8 +: 8];
          checks++;
          assert (expQ.size() > 0) else begin
            errors++;
            $error("[TB] FAIL sb_extra observed=%h expected=none", obs);
          end
          if (expQ.size() > 0) begin
            exp = expQ.pop_front();
            checks++;
            assert (obs === exp) else begin
              errors++;
              $error("[TB] FAIL sb_beat observed=%h expected=%h", obs, exp);
            end
          end
        end
      end
      if (d3Err) d3ErrPulses++;
      if (d3Busy) d3BusyCycles++;
    end
  end

  // Generic directed comparison.
  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Offer one beat to the 4-lane DUT; on acceptance record where it must emerge.
  task automatic applyStimulus(input logic [7:0] data, input logic [1:0] sel, input logic last);
    bit done = 1'b0;
    inValid = 1'b1;
    inData  = data;
    inSel   = sel;
    inLast  = last;
    for (int c = 0; c < 50 && !done; c++) begin
      @(negedge clk);
      if (inReady) begin
        if (!mInPkt) mLane = sel;
        expQ.push_back('{ch: mLane, last: last, data: data});
        mInPkt = !last;
        done = 1'b1;
      end
      @(posedge clk); #1;
    end
    inValid = 1'b0;
    checks++;
    assert (done) else begin
      errors++;
      $error("[TB] FAIL accept_timeout observed=not accepted expected=accepted data=%h", data);
    end
  endtask

  task automatic idleCycles(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic pulseReset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    expQ.delete();
    mInPkt = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    inValid = 1'b0; inData = '0; inSel = '0; inLast = 1'b0;
    outReady = 4'hF;
    d3InValid = 1'b0; d3InData = '0; d3InSel = '0; d3InLast = 1'b0;
    d3OutReady = 3'b111;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_valid", 64'(outValid), 64'h0);
    checkOutput("rst_data", 64'(outData), 64'h0);
    checkOutput("rst_last", 64'(outLast), 64'h0);
    checkOutput("rst_err", 64'(err), 64'h0);
    checkOutput("rst_busy", 64'(busy), 64'h0);
    checkOutput("rst_ready", 64'(inReady), 64'h1);
    rst = 1'b0;
    idleCycles(1);

    $display("[TB] 3-beat packet to lane 2");
    applyStimulus(8'h11, 2'd2, 1'b0);
    checkOutput("t1_latency", 64'(outValid), 64'b0100);
    checkOutput("t1_busy", 64'(busy), 64'h1);
    applyStimulus(8'h22, 2'd2, 1'b0);
    checkOutput("t1_beat2", 64'(outData[23:16]), 64'h22);
    applyStimulus(8'h33, 2'd2, 1'b1);
    checkOutput("t1_last", 64'(outLast), 64'b0100);
    checkOutput("t1_busy_end", 64'(busy), 64'h0);
    idleCycles(2);
    checkOutput("t1_drained", 64'(outValid), 64'h0);

    $display("[TB] select changes mid-packet are ignored");
    applyStimulus(8'h41, 2'd1, 1'b0);
    applyStimulus(8'h42, 2'd3, 1'b0);
    applyStimulus(8'h43, 2'd3, 1'b0);
    checkOutput("t2_lane", 64'(outValid), 64'b0010);
    applyStimulus(8'h44, 2'd3, 1'b1);
    idleCycles(2);

    $display("[TB] stall on lane 0 while lane 3 is ready");
    applyStimulus(8'hA1, 2'd0, 1'b0);
    outReady = 4'b1000;
    inValid = 1'b1; inData = 8'hA2; inSel = 2'd0; inLast = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("t3_ready_low", 64'(inReady), 64'h0);
      checkOutput("t3_hold", 64'({outValid[0], outData[7:0]}), 64'h1A1);
      @(posedge clk); #1;
    end
    outReady = 4'hF;
    applyStimulus(8'hA2, 2'd0, 1'b0);
    applyStimulus(8'hA3, 2'd0, 1'b1);
    idleCycles(2);
    checkOutput("t3_sb_empty", 64'(expQ.size()), 64'h0);

    $display("[TB] out-of-range packet on 3-lane instance");
    d3InValid = 1'b1; d3InSel = 2'd3; d3InData = 8'h55; d3InLast = 1'b0;
    @(negedge clk);
    checkOutput("t4_ready1", 64'(d3InReady), 64'h1);
    checkOutput("t4_err_pre", 64'(d3Err), 64'h0);
    @(posedge clk); #1;
    checkOutput("t4_err_pulse", 64'(d3Err), 64'h1);
    checkOutput("t4_busy", 64'(d3Busy), 64'h1);
    d3InData = 8'h66; d3InLast = 1'b1;
    @(negedge clk);
    checkOutput("t4_ready2", 64'(d3InReady), 64'h1);
    @(posedge clk); #1;
    d3InValid = 1'b0;
    checkOutput("t4_err_once", 64'(d3Err), 64'h0);
    checkOutput("t4_busy_end", 64'(d3Busy), 64'h0);
    checkOutput("t4_no_valid", 64'(d3OutValid), 64'h0);
    checkOutput("t4_no_data", 64'({d3OutData, d3OutLast}), 64'h0);
    idleCycles(2);
    checkOutput("t4_err_count", 64'(d3ErrPulses), 64'd1);
    checkOutput("t4_busy_count", 64'(d3BusyCycles), 64'd1);
`ifdef DEMUX_1XN_CNT_EN
    checkOutput("t4_drop_cnt", 64'(d3DropCnt), 64'd1);
`endif

    $display("[TB] reset during ROUTE with a held beat");
    outReady = 4'h0;
    applyStimulus(8'h77, 2'd1, 1'b0);
    checkOutput("t6_busy", 64'(busy), 64'h1);
    checkOutput("t6_held", 64'(outValid), 64'b0010);
    rst = 1'b1;
    #1;
    checkOutput("t6_rst_valid", 64'(outValid), 64'h0);
    checkOutput("t6_rst_data", 64'({outData, outLast}), 64'h0);
    checkOutput("t6_rst_busy", 64'(busy), 64'h0);
    checkOutput("t6_rst_ready", 64'(inReady), 64'h1);
    expQ.delete();
    mInPkt = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    outReady = 4'hF;
    applyStimulus(8'h88, 2'd3, 1'b1);
    checkOutput("t6_after", 64'({outValid, outData[31:24]}), 64'h888);
    idleCycles(2);

    $display("[TB] back-to-back single-beat packets");
    pulseReset();
    applyStimulus(8'hC0, 2'd0, 1'b1);
    checkOutput("t5_l0", 64'(outValid), 64'b0001);
    applyStimulus(8'hC1, 2'd1, 1'b1);
    checkOutput("t5_l1", 64'(outValid), 64'b0010);
    applyStimulus(8'hC2, 2'd2, 1'b1);
    checkOutput("t5_l2", 64'(outValid), 64'b0100);
    applyStimulus(8'hC3, 2'd3, 1'b1);
    checkOutput("t5_l3", 64'(outValid), 64'b1000);
    checkOutput("t5_busy", 64'(busy), 64'h0);
    idleCycles(3);
`ifdef DEMUX_1XN_CNT_EN
    checkOutput("t5_pkt_cnt", pktCnt, 64'h0001_0001_0001_0001);
`endif
    checkOutput("final_sb_empty", 64'(expQ.size()), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
